sr_bank_scheduler: RTL

SR_BANK_SCHEDULER -- requirements
Module: sr_bank_scheduler

---
 rtl/sr_bank_scheduler.sv | 89 ++++++++
 1 files changed

// File: rtl/sr_bank_scheduler.sv
// sr_bank_scheduler: round-robin scheduler issuing S/R pulses to an external SR flip-flop bank.
// Define SR_CONFLICT_CHECK_EN to flag simultaneous set+clear requests as errors instead of clear-wins.
module sr_bank_scheduler #(
    parameter int NREQ      = 4,
    parameter int NFLAG     = 8,
    parameter int PULSE_CYC = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   req_set,
    input  logic [NREQ-1:0]   req_clr,
    input  logic [NREQ*3-1:0] req_idx,
    output logic [NREQ-1:0]   ack,
    output logic [NFLAG-1:0]  S_out,
    output logic [NFLAG-1:0]  R_out,
    input  logic [NFLAG-1:0]  Q_in,
    output logic              busy,
    output logic              err
);
    localparam int GW = NREQ > 1 ? $clog2(NREQ) : 1;
    typedef enum logic [1:0] {IDLE, PULSE, SETTLE, ACK} state_t;
    state_t state, state_nx;
    logic [GW-1:0] last, gnt, gnt_r;
    logic [3:0] cnt;
    logic [2:0] idx, gnt_idx;
    logic op_set, found, bad, conflict;
    logic [NFLAG-1:0] mask;
    logic [NREQ-1:0] pending;
    int c;
    assign pending = req_set | req_clr;
    assign mask    = NFLAG'(1) << idx;
    assign gnt_idx = 3'(req_idx >> (3 * int'(gnt)));
    assign bad     = int'(gnt_idx) >= NFLAG;
`ifdef SR_CONFLICT_CHECK_EN
    assign conflict = req_set[gnt] & req_clr[gnt];
`else
    assign conflict = 1'b0;
`endif
    assign busy  = state != IDLE;
    assign S_out = (state == PULSE && op_set) ? mask : '0;
    assign R_out = (state == PULSE && !op_set) ? mask : '0;
    assign ack   = (state == ACK) ? NREQ'(1) << gnt_r : '0;
    // Search starts one past the last grant so a busy requester cannot starve the others
    always_comb begin
        found = 1'b0;
        gnt = last;
        c = 0;
        for (int i = 1; i <= NREQ; i++) begin
            c = (int'(last) + i) % NREQ;
            if (!found && |(pending & (NREQ'(1) << c))) begin
                found = 1'b1;
                gnt = GW'(c);
            end
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (found) state_nx = (bad || conflict) ? ACK : PULSE;
            PULSE:   if (cnt == 4'(PULSE_CYC - 1)) state_nx = SETTLE;
            SETTLE:  state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            last   <= GW'(NREQ - 1);
            gnt_r  <= '0;
            cnt    <= '0;
            idx    <= '0;
            op_set <= 1'b0;
            err    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && found) begin
                last   <= gnt;
                gnt_r  <= gnt;
                idx    <= gnt_idx;
                op_set <= req_set[gnt] & ~req_clr[gnt];
                cnt    <= '0;
                if (bad || conflict) err <= 1'b1;
            end
            if (state == PULSE) cnt <= cnt + 4'd1;
            if (state == SETTLE && (|(Q_in & mask)) != op_set) err <= 1'b1;
        end
    end
endmodule
